// File: rtl/sequence_010110_generator.sv
// sequence_010110_generator: bursts of N serial PATTERN frames, optionally sharing the boundary 0
module sequence_010110_generator #(
    parameter logic [5:0] PATTERN = 6'b010110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] n,
    input  logic       m,
    input  logic       en,
    input  logic       abort,
    output logic       x,
    output logic       valid,
    output logic       busy,
    output logic       frame_end,
    output logic       done,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, FINISH = 2'b10} state_t;
    state_t     st;
    logic [2:0] bit_idx;
    logic [3:0] frm_cnt;
    logic       m_r;
    assign state = st;
    // burst FSM with registered serial output; frame_end/done are single-cycle pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            x         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_end <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= 3'd0;
            frm_cnt   <= 4'd0;
            m_r       <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            done      <= 1'b0;
            case (st)
                IDLE: begin
                    x <= 1'b0;
                    if (start && !abort) begin
                        st      <= SEND;
                        m_r     <= m;
                        frm_cnt <= (n == 4'd0) ? 4'd1 : n;
                        bit_idx <= 3'd5;
                        x       <= PATTERN[5];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (abort) begin
                        st        <= IDLE;
                        x         <= 1'b0;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        bit_idx   <= 3'd0;
                        frm_cnt   <= 4'd0;
                        frame_end <= en && (bit_idx == 3'd0);
                    end else if (en) begin
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            x       <= PATTERN[bit_idx - 3'd1];
                        end else begin
                            frame_end <= 1'b1;
                            if (frm_cnt > 4'd1) begin
                                frm_cnt <= frm_cnt - 4'd1;
                                bit_idx <= m_r ? 3'd4 : 3'd5;
                                x       <= m_r ? PATTERN[4] : PATTERN[5];
                            end else begin
                                st    <= FINISH;
                                done  <= 1'b1;
                                valid <= 1'b0;
                                x     <= 1'b0;
                            end
                        end
                    end
                end
                FINISH: begin
                    st      <= IDLE;
                    x       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    bit_idx <= 3'd0;
                    frm_cnt <= 4'd0;
                end
                default: begin
                    st      <= IDLE;
                    x       <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    bit_idx <= 3'd0;
                    frm_cnt <= 4'd0;
                    m_r     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_010110_generator.sv
// tb_sequence_010110_generator: table-driven and burst-sequence checks of the 010110 generator
module tb_sequence_010110_generator;
    logic       clk = 1'b0;
    logic       reset, start, m, en, abort;
    logic [3:0] n;
    logic       x, valid, busy, frame_end, done;
    logic [1:0] state;
    int         n_chk = 0;
    int         n_fail = 0;

    sequence_010110_generator dut (
        .clk(clk), .reset(reset), .start(start), .n(n), .m(m), .en(en), .abort(abort),
        .x(x), .valid(valid), .busy(busy), .frame_end(frame_end), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] n;
        logic       m;
        logic       en;
        logic       abort;
        logic [6:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {x, valid, busy, frame_end, done, state};
    endfunction

    task automatic run_burst(input logic [3:0] nn, input logic mm, input int toggle, input int gs,
                             input int ab, input int rs, output logic [31:0] str, output int nb,
                             output int nfe, output int nd);
        bit fin = 0;
        str = 0; nb = 0; nfe = 0; nd = 0;
        start = 1'b1; n = nn; m = mm; en = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; n = 4'd15; m = ~mm;
        check("start_accepted", {30'd0, state}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            en    = toggle ? (i % 3 == 0) : 1'b1;
            start = (i == gs);
            abort = (i == ab);
            if (i == rs) begin
                reset = 1'b1; #1;
                check("reset_mid_burst", {25'd0, outs()}, 32'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                fin = 1;
                break;
            end
            if (valid && en && !abort) begin
                str = {str[30:0], x};
                nb++;
            end
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            nfe += frame_end;
            nd  += done;
            if (i == ab) begin
                check("abort_idle", {28'd0, x, valid, state}, 32'd0);
                fin = 1;
                break;
            end
            if (state == 2'd0) begin
                fin = 1;
                break;
            end
        end
        check("burst_terminated", {31'd0, fin}, 32'd1);
        en = 1'b0;
    endtask

    vec_t        tbl[25];
    logic [31:0] s;
    int          b, f, d;

    initial begin
        tbl[0]  = '{1, 1, 0, 1, 0, 7'b0110001};
        tbl[1]  = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[2]  = '{0, 1, 0, 1, 0, 7'b0110001};
        tbl[3]  = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[4]  = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[5]  = '{0, 1, 0, 1, 0, 7'b0110001};
        tbl[6]  = '{0, 1, 0, 1, 0, 7'b0011110};
        tbl[7]  = '{0, 1, 0, 1, 0, 7'b0000000};
        tbl[8]  = '{1, 1, 0, 0, 0, 7'b0110001};
        tbl[9]  = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[10] = '{0, 1, 0, 0, 0, 7'b1110001};
        tbl[11] = '{0, 1, 0, 0, 0, 7'b1110001};
        tbl[12] = '{0, 1, 0, 1, 0, 7'b0110001};
        tbl[13] = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[14] = '{0, 1, 0, 0, 0, 7'b1110001};
        tbl[15] = '{0, 1, 0, 1, 0, 7'b1110001};
        tbl[16] = '{0, 1, 0, 1, 0, 7'b0110001};
        tbl[17] = '{0, 1, 0, 0, 0, 7'b0110001};
        tbl[18] = '{0, 1, 0, 1, 0, 7'b0011110};
        tbl[19] = '{0, 1, 0, 0, 0, 7'b0000000};
        tbl[20] = '{1, 1, 0, 1, 1, 7'b0000000};
        tbl[21] = '{0, 1, 0, 1, 0, 7'b0000000};
        tbl[22] = '{1, 1, 0, 1, 0, 7'b0110001};
        tbl[23] = '{0, 1, 0, 1, 1, 7'b0000000};
        tbl[24] = '{0, 1, 0, 1, 0, 7'b0000000};
        reset = 1'b1; start = 1'b0; n = 4'd1; m = 1'b0; en = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {25'd0, outs()}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            start = tbl[i].start; n = tbl[i].n; m = tbl[i].m; en = tbl[i].en; abort = tbl[i].abort;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), {25'd0, outs()}, {25'd0, tbl[i].exp});
        end
        start = 1'b0; abort = 1'b0; en = 1'b0;
        @(posedge clk); #1;

        run_burst(4'd3, 1'b1, 0, -1, -1, -1, s, b, f, d);
        check("ovl3_stream", s, 32'b0101101011010110);
        check("ovl3_bits", b, 16);
        check("ovl3_fe", f, 3);
        check("ovl3_done", d, 1);

        run_burst(4'd2, 1'b0, 0, -1, -1, -1, s, b, f, d);
        check("full2_stream", s, 32'b010110010110);
        check("full2_bits", b, 12);
        check("full2_fe", f, 2);
        check("full2_done", d, 1);

        run_burst(4'd2, 1'b1, 1, -1, -1, -1, s, b, f, d);
        check("stall_stream", s, 32'b01011010110);
        check("stall_bits", b, 11);
        check("stall_fe", f, 2);

        run_burst(4'd0, 1'b0, 0, -1, -1, -1, s, b, f, d);
        check("n0_stream", s, 32'b010110);
        check("n0_bits", b, 6);
        check("n0_fe", f, 1);

        run_burst(4'd1, 1'b0, 0, 2, -1, -1, s, b, f, d);
        check("glitch_bits", b, 6);
        check("glitch_done", d, 1);
        @(posedge clk); #1;
        check("glitch_idle", {30'd0, state}, 32'd0);

        run_burst(4'd3, 1'b0, 0, -1, 9, -1, s, b, f, d);
        check("abort_stream", s, 32'b010110010);
        check("abort_bits", b, 9);
        check("abort_fe", f, 1);
        check("abort_done", d, 0);

        run_burst(4'd2, 1'b0, 0, -1, 5, -1, s, b, f, d);
        check("abort_fe_coinc", f, 1);
        check("abort_coinc_done", d, 0);

        run_burst(4'd3, 1'b0, 0, -1, -1, 9, s, b, f, d);
        check("reset_bits", b, 9);
        check("reset_fe", f, 1);
        check("reset_done", d, 0);

        run_burst(4'd1, 1'b0, 0, -1, -1, -1, s, b, f, d);
        check("post_reset_stream", s, 32'b010110);
        check("post_reset_done", d, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sequence_010110_generator.md
SEQUENCE_010110_GENERATOR -- requirements
Module: sequence_010110_generator

Interface
REQ-001 The block SHALL have parameter PATTERN, default 6'b010110, the frame pattern sent MSB first.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, reset, asynchronous, active-high; the clock is clk.
REQ-004 The block SHALL have port start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-005 The block SHALL have port n, input, 4, number of frames in the burst; 0 is treated as 1.
REQ-006 The block SHALL have port m, input, 1, overlap mode: 1 = frames share the boundary 0, 0 = full frames.
REQ-007 The block SHALL have port en, input, 1, bit-strobe; the bit on x is consumed on a rising edge only while en=1.
REQ-008 The block SHALL have port abort, input, 1, terminate the burst.
REQ-009 The block SHALL have port x, output, 1, registered serial data.
REQ-010 The block SHALL have port valid, output, 1, x carries a pattern bit (high only in SEND).
REQ-011 The block SHALL have port busy, output, 1, high in SEND and FINISH.
REQ-012 The block SHALL have port frame_end, output, 1, one-cycle pulse after the last bit of each frame is consumed.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse on normal burst completion.
REQ-014 The block SHALL have port state, output, 2, current state: IDLE=00, SEND=01, FINISH=10.

Function
REQ-015 States SHALL be IDLE, SEND and FINISH; encoding 11 SHALL return to IDLE on the next edge with all outputs at their reset values.
REQ-016 IDLE with start=1 SHALL go to SEND on the next edge and latch m and max(n,1) into internal registers; x SHALL be loaded with PATTERN[5] and bit_idx SHALL be set to 5.
REQ-017 start seen outside IDLE SHALL be ignored; changes to n and m during a burst SHALL have no effect.
REQ-018 In SEND with en=0, x, bit_idx and the frame count SHALL hold.
REQ-019 In SEND with en=1 and bit_idx>0, bit_idx SHALL decrement and x SHALL be loaded with PATTERN[bit_idx-1].
REQ-020 In SEND with en=1 and bit_idx=0, the frame is complete and frame_end SHALL be 1 in the following cycle.
REQ-021 On frame completion with frames remaining > 1, the frame count SHALL decrement, and the next frame SHALL start in the next cycle with no gap.
REQ-022 The next frame SHALL start at bit_idx=5 (x=0) if m=0, or at bit_idx=4 (x=1) if m=1, so the shared leading 0 is not sent again.
REQ-023 On completion of the last frame, the state SHALL go to FINISH; in FINISH, done=1 and valid=0, and the state SHALL go to IDLE on the next edge.
REQ-024 Total bits consumed per burst SHALL be 6*N for m=0 and 6+5*(N-1) for m=1, where N=max(n,1).
REQ-025 abort=1 in SEND or FINISH SHALL force IDLE on the next edge with x=0 and valid=0; done SHALL NOT pulse; if abort coincides with frame completion, frame_end SHALL still pulse.
REQ-026 abort SHALL take priority over en; abort in IDLE SHALL take priority over start, so the burst does not start.
REQ-027 In IDLE, x SHALL be 0.
REQ-028 The bit counter SHALL be 3 bits; the frame counter SHALL be 4 bits and SHALL NOT wrap below 1.
REQ-029 The bit stream SHALL be accepted by the team's 010110 detector with the same m: one detection per frame.

Reset
REQ-030 While reset=1, the block SHALL hold state=IDLE and x, valid, busy, frame_end and done at 0, with bit_idx=0 and frame count=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst immediately, with no done and no frame_end.
REQ-032 After reset deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-033 Single frame: n=1, m=0, en=1 constant, start pulse -> x=0,1,0,1,1,0 on 6 valid cycles; frame_end in cycle 7; done in cycle 7 with state=FINISH; IDLE in cycle 8.
REQ-034 Overlap burst: n=3, m=1, en=1 -> stream 010110 10110 10110 (16 bits); 3 frame_end pulses; 1 done; the detector in m=1 reports z 3 times.
REQ-035 Non-overlap burst: n=2, m=0 -> 12 bits, 010110010110; detector in m=0 reports 2 detections.
REQ-036 Stall: en toggling 1,0,0,1,... -> x holds across en=0 cycles; bit order unchanged; total en=1 cycles equals the bit count.
REQ-037 Abort and reset: abort at bit_idx=2 of frame 2 -> IDLE next edge, x=0, no done; repeat with reset instead -> same result, and a start right after reset is accepted.
REQ-038 Edge inputs: n=0 -> exactly one frame; a start pulse during SEND -> ignored, burst length unchanged.
